// File: rtl/riscv_pkg.sv
// Shared types for the cache write path: AMO write port and write-queue entry.
package riscv_pkg;

  localparam int WQ_XLEN    = 32;
  localparam int WQ_INDEX_W = 7;
  localparam int WQ_TAG_W   = 7;

  typedef struct packed {
    logic               write_enable;
    logic [WQ_XLEN-1:0] addr;
    logic [WQ_XLEN-1:0] data;
  } amo_interface_t;

  // One pending cache write; is_store selects merge-with-valid behaviour.
  typedef struct packed {
    logic [WQ_INDEX_W-1:0] index;
    logic [WQ_TAG_W-1:0]   tag;
    logic [WQ_XLEN-1:0]    data;
    logic [WQ_XLEN/8-1:0]  be;
    logic                  is_store;
  } wq_entry_t;

endpackage

// File: rtl/cache_way_select.sv
// Picks the target way for a cache write: tag hit, then an empty way,
// then a round-robin victim that only moves when it was actually used.
module cache_way_select #(
  parameter int NumWays = 2,
  parameter int TagW    = 7,
  parameter int BeW     = 4,
  parameter int WayW    = 1
)(
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          we,
  input  logic [TagW-1:0]               tag,
  input  logic [NumWays-1:0][TagW-1:0]  rd_tag,
  input  logic [NumWays-1:0][BeW-1:0]   rd_valid,
  output logic [WayW-1:0]               way,
  output logic                          hit
);

  logic [WayW-1:0] victim, hit_way, inv_way;
  logic            inv, alloc_ptr;

  // Scan from the top down so the lowest-numbered candidate wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    inv     = 1'b0;
    inv_way = '0;
    for (int w = NumWays - 1; w >= 0; w--) begin
      if (rd_tag[w] == tag && |rd_valid[w]) begin
        hit     = 1'b1;
        hit_way = WayW'(w);
      end
      if (rd_valid[w] == '0) begin
        inv     = 1'b1;
        inv_way = WayW'(w);
      end
    end
    alloc_ptr = ~hit & ~inv;
    if (NumWays == 1)  way = '0;
    else if (hit)      way = hit_way;
    else if (inv)      way = inv_way;
    else               way = victim;
  end

  // Victim advances mod NumWays only when a write consumed it.
  always_ff @(posedge i_clk) begin
    if (i_rst)
      victim <= '0;
    else if (we && alloc_ptr)
      victim <= (victim == WayW'(NumWays - 1)) ? '0 : victim + 1'b1;
  end

endmodule

// File: rtl/cache_write_queue.sv
// Write queue in front of the data cache: buffers stores and load fills,
// lets AMO writes bypass, and drives the single cache write port.
module cache_write_queue
  import riscv_pkg::*;
#(
  parameter int               XLEN            = 32,
  parameter int               CacheIndexWidth = 7,
  parameter int               CacheTagWidth   = 7,
  parameter int               NumWays         = 2,
  parameter int               QueueDepth      = 4,
  parameter logic [XLEN-1:0]  MMIO_ADDR       = 32'h4000_0000
)(
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_stall,
  input  logic                                 i_flush,
  input  logic [XLEN-1:0]                      i_st_addr,
  input  logic [XLEN-1:0]                      i_st_data,
  input  logic [XLEN/8-1:0]                    i_st_be,
  input  logic                                 i_ld_valid,
  input  logic [XLEN-1:0]                      i_ld_addr,
  input  logic [XLEN-1:0]                      i_ld_data,
  input  amo_interface_t                       i_amo,
  input  logic [CacheIndexWidth-1:0]           i_probe_index,
  input  logic [NumWays-1:0][CacheTagWidth-1:0] i_rd_tag,
  input  logic [NumWays-1:0][XLEN/8-1:0]       i_rd_valid,
  output logic                                 o_we,
  output logic [(NumWays>1 ? $clog2(NumWays) : 1)-1:0] o_way,
  output logic [CacheIndexWidth-1:0]           o_index,
  output logic [XLEN-1:0]                      o_data,
  output logic [CacheTagWidth-1:0]             o_tag,
  output logic [XLEN/8-1:0]                    o_byte_we,
  output logic [XLEN/8-1:0]                    o_valid,
  output logic                                 o_full,
  output logic                                 o_empty,
  output logic                                 o_probe_hit
);

  localparam int BeW  = XLEN / 8;
  localparam int WayW = (NumWays > 1) ? $clog2(NumWays) : 1;
  localparam int IW   = $clog2(QueueDepth);
  localparam int PW   = IW + 1;

  wq_entry_t                   mem [QueueDepth];
  logic [PW-1:0]               wr_ptr, rd_ptr, count;
  logic [IW-1:0]               wr_idx;
  logic                        fill_r;
  logic [CacheIndexWidth-1:0]  fill_index;
  logic [CacheTagWidth-1:0]    fill_tag;
  logic [XLEN-1:0]             fill_data;
  logic                        st_mmio, ld_mmio, amo_mmio, amo_act;
  logic                        st_enq, fill_enq, pop, is_store_out, hit;
  wq_entry_t                   fill_e, st_e, head;

  assign st_mmio  = i_st_addr >= MMIO_ADDR;
  assign ld_mmio  = i_ld_addr >= MMIO_ADDR;
  assign amo_mmio = i_amo.addr >= MMIO_ADDR;
  assign amo_act  = i_amo.write_enable & ~amo_mmio;

  assign count    = wr_ptr - rd_ptr;
  assign wr_idx   = wr_ptr[IW-1:0];
  assign head     = mem[rd_ptr[IW-1:0]];
  assign o_full   = count >= PW'(QueueDepth - 1);
  assign o_empty  = count == '0;

  // A flush kills a fill still in flight; already-queued entries are committed.
  assign fill_enq = fill_r & ~i_flush;
  assign st_enq   = |i_st_be & ~i_stall & ~st_mmio & ~o_full;

  assign fill_e = '{index: fill_index, tag: fill_tag, data: fill_data, be: '1, is_store: 1'b0};
  assign st_e   = '{index: i_st_addr[2 +: CacheIndexWidth],
                    tag: i_st_addr[2+CacheIndexWidth +: CacheTagWidth],
                    data: i_st_data, be: i_st_be, is_store: 1'b1};

  // Load fill is registered one cycle so it lines up with the store stage.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) fill_r <= 1'b0;
    else                  fill_r <= i_ld_valid & ~ld_mmio & ~i_stall;
  end

  // Fill payload holds across stalls; not reset, qualified by fill_r.
  always_ff @(posedge i_clk) begin
    if (!i_stall) begin
      fill_index <= i_ld_addr[2 +: CacheIndexWidth];
      fill_tag   <= i_ld_addr[2+CacheIndexWidth +: CacheTagWidth];
      fill_data  <= i_ld_data;
    end
  end

  // Entry storage; a coincident fill takes the older slot ahead of the store.
  always_ff @(posedge i_clk) begin
    if (fill_enq) mem[wr_idx] <= fill_e;
    if (st_enq)   mem[wr_idx + IW'(fill_enq)] <= st_e;
  end

  // Extra pointer bit distinguishes full from empty on wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(fill_enq) + PW'(st_enq);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Write port mux: AMO owns the port when present, else the queue head.
  always_comb begin
    o_we         = ~i_rst & (amo_act | ~o_empty);
    pop          = o_we & ~amo_act;
    o_index      = head.index;
    o_tag        = head.tag;
    o_data       = head.data;
    o_byte_we    = head.be;
    is_store_out = head.is_store;
    if (amo_act) begin
      o_index      = i_amo.addr[2 +: CacheIndexWidth];
      o_tag        = i_amo.addr[2+CacheIndexWidth +: CacheTagWidth];
      o_data       = i_amo.data;
      o_byte_we    = '1;
      is_store_out = 1'b0;
    end
    if (!is_store_out) o_valid = '1;
    else if (hit)      o_valid = o_byte_we | i_rd_valid[o_way];
    else               o_valid = o_byte_we;
  end

  // Probe: any live slot (offset from head below occupancy) or the fill.
  always_comb begin
    logic [IW-1:0] off;
    o_probe_hit = fill_r & (fill_index == i_probe_index);
    for (int i = 0; i < QueueDepth; i++) begin
      off = IW'(i) - rd_ptr[IW-1:0];
      if ({1'b0, off} < count && mem[i].index == i_probe_index)
        o_probe_hit = 1'b1;
    end
  end

  cache_way_select #(
    .NumWays (NumWays),
    .TagW    (CacheTagWidth),
    .BeW     (BeW),
    .WayW    (WayW)
  ) u_way_sel (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .we       (o_we),
    .tag      (o_tag),
    .rd_tag   (i_rd_tag),
    .rd_valid (i_rd_valid),
    .way      (o_way),
    .hit      (hit)
  );

endmodule

// File: tb/tb_cache_write_queue.sv
// Directed bench: stimulus pushes expected cache writes, a negedge monitor
// pops and compares every write the DUT issues. A tiny tag/valid array
// stands in for the cache so way selection sees realistic state.
module tb_cache_write_queue;
  import riscv_pkg::*;

  logic              i_clk = 0, i_rst, i_stall, i_flush;
  logic [31:0]       i_st_addr, i_st_data, i_ld_addr, i_ld_data;
  logic [3:0]        i_st_be;
  logic              i_ld_valid;
  amo_interface_t    i_amo;
  logic [6:0]        i_probe_index;
  logic [1:0][6:0]   i_rd_tag;
  logic [1:0][3:0]   i_rd_valid;
  logic              o_we, o_way, o_full, o_empty, o_probe_hit;
  logic [6:0]        o_index, o_tag;
  logic [31:0]       o_data;
  logic [3:0]        o_byte_we, o_valid;

  cache_write_queue dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_stall(i_stall), .i_flush(i_flush),
    .i_st_addr(i_st_addr), .i_st_data(i_st_data), .i_st_be(i_st_be),
    .i_ld_valid(i_ld_valid), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
    .i_amo(i_amo), .i_probe_index(i_probe_index),
    .i_rd_tag(i_rd_tag), .i_rd_valid(i_rd_valid),
    .o_we(o_we), .o_way(o_way), .o_index(o_index), .o_data(o_data),
    .o_tag(o_tag), .o_byte_we(o_byte_we), .o_valid(o_valid),
    .o_full(o_full), .o_empty(o_empty), .o_probe_hit(o_probe_hit)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [6:0]  idx;
    logic [6:0]  tag;
    logic [31:0] data;
    logic        way;
    logic [3:0]  be;
    logic [3:0]  vld;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_amo[$];
  int   n_chk = 0, n_fail = 0;

  // Cache tag/valid model, updated from the DUT's own writes.
  logic [6:0] ctag [128][2];
  logic [3:0] cval [128][2];
  initial for (int i = 0; i < 128; i++) begin
    ctag[i][0] = '0; ctag[i][1] = '0; cval[i][0] = '0; cval[i][1] = '0;
  end
  always @(posedge i_clk) if (o_we) begin
    ctag[o_index][o_way] <= o_tag;
    cval[o_index][o_way] <= o_valid;
  end
  always_comb for (int w = 0; w < 2; w++) begin
    i_rd_tag[w]   = ctag[o_index][w];
    i_rd_valid[w] = cval[o_index][w];
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [6:0] idx, input logic [6:0] tag,
                              input logic [31:0] data, input logic way,
                              input logic [3:0] be, input logic [3:0] vld);
    exp_t e;
    e.idx = idx; e.tag = tag; e.data = data; e.way = way; e.be = be; e.vld = vld;
    return e;
  endfunction

  // Monitor: AMO writes come from the bypass list, all others from the queue list.
  always @(negedge i_clk) begin
    exp_t e;
    logic amo_now;
    if (o_we) begin
      amo_now = i_amo.write_enable && (i_amo.addr < 32'h4000_0000);
      if (amo_now ? exp_amo.size() == 0 : exp_q.size() == 0) begin
        cmp("unexpected_write", {25'd0, o_index}, 32'hFFFF_FFFF);
      end else begin
        e = amo_now ? exp_amo.pop_front() : exp_q.pop_front();
        cmp("wr_index", {25'd0, o_index}, {25'd0, e.idx});
        cmp("wr_tag",   {25'd0, o_tag},   {25'd0, e.tag});
        cmp("wr_data",  o_data,           e.data);
        cmp("wr_way",   {31'd0, o_way},   {31'd0, e.way});
        cmp("wr_be",    {28'd0, o_byte_we}, {28'd0, e.be});
        cmp("wr_valid", {28'd0, o_valid}, {28'd0, e.vld});
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic idle();
    i_st_addr = '0; i_st_data = '0; i_st_be = '0;
    i_ld_valid = 0; i_ld_addr = '0; i_ld_data = '0;
    i_amo = '0; i_stall = 0; i_flush = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    i_st_addr = a; i_st_data = d; i_st_be = be;
  endtask

  task automatic amo(input logic [31:0] a, input logic [31:0] d);
    i_amo.write_enable = 1; i_amo.addr = a; i_amo.data = d;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); i_probe_index = '0; i_rst = 1;
    tick(); tick();
    @(negedge i_clk);
    cmp("rst_we_held", {31'd0, o_we}, 0);
    tick();
    i_rst = 0;
    @(negedge i_clk);
    cmp("rst_we", {31'd0, o_we}, 0);
    cmp("rst_empty", {31'd0, o_empty}, 1);
    cmp("rst_full", {31'd0, o_full}, 0);
    cmp("rst_probe", {31'd0, o_probe_hit}, 0);
    tick();

    // Single partial store into an empty cache.
    store(32'h104, 32'hAABBCCDD, 4'b0011);
    exp_q.push_back(mk(7'h41, 0, 32'hAABBCCDD, 0, 4'b0011, 4'b0011));
    tick();
    idle(); i_probe_index = 7'h41;
    @(negedge i_clk);
    cmp("probe_queued", {31'd0, o_probe_hit}, 1);
    cmp("we_after_store", {31'd0, o_we}, 1);
    tick();
    @(negedge i_clk);
    cmp("probe_drained", {31'd0, o_probe_hit}, 0);
    cmp("empty_drained", {31'd0, o_empty}, 1);
    tick();

    // Load fill then store to the same line: fill first, both fully valid.
    i_ld_valid = 1; i_ld_addr = 32'h104; i_ld_data = 32'h11112222;
    tick();
    idle(); store(32'h104, 32'h33334444, 4'b1100);
    exp_q.push_back(mk(7'h41, 0, 32'h11112222, 0, 4'hF, 4'hF));
    exp_q.push_back(mk(7'h41, 0, 32'h33334444, 0, 4'b1100, 4'hF));
    tick();
    idle(); tick(); tick(); tick();

    // AMO bypasses two queued entries.
    i_ld_valid = 1; i_ld_addr = 32'h300; i_ld_data = 32'h55556666;
    tick();
    idle(); store(32'h404, 32'h77778888, 4'b0001);
    exp_q.push_back(mk(7'h40, 1, 32'h55556666, 0, 4'hF, 4'hF));
    exp_q.push_back(mk(7'h01, 2, 32'h77778888, 0, 4'b0001, 4'b0001));
    tick();
    idle(); amo(32'h200, 32'h9999AAAA);
    exp_amo.push_back(mk(7'h00, 1, 32'h9999AAAA, 0, 4'hF, 4'hF));
    @(negedge i_clk);
    cmp("amo_head_held", {31'd0, o_empty}, 0);
    tick();
    idle(); tick(); tick();
    @(negedge i_clk);
    cmp("amo_drained", {31'd0, o_empty}, 1);
    tick();

    // Four tags at index 5: empty way, empty way, victim 0, victim 1.
    for (int k = 1; k <= 4; k++) begin
      store((k << 9) | 32'h14, 32'h01010101 * k, 4'hF);
      exp_q.push_back(mk(7'h05, 7'(k), 32'h01010101 * k, (k % 2) == 0, 4'hF, 4'hF));
      tick();
    end
    idle(); tick(); tick(); tick();

    // AMO holds the head while three stores fill the queue; MMIO store dropped.
    for (int j = 0; j < 4; j++) begin
      amo(32'h200, 32'hA0A0_0000 + j);
      exp_amo.push_back(mk(7'h00, 1, 32'hA0A0_0000 + j, 0, 4'hF, 4'hF));
      if (j < 3) begin
        store(32'h40 + 4 * j, 32'hC0DE_0000 + j, 4'hF);
        exp_q.push_back(mk(7'h10 + 7'(j), 0, 32'hC0DE_0000 + j, 0, 4'hF, 4'hF));
      end else begin
        store(32'h4000_0000, 32'hBAD0_0000, 4'hF);
      end
      @(negedge i_clk);
      if (j == 2) cmp("not_full_at_2", {31'd0, o_full}, 0);
      if (j == 3) cmp("full_at_3", {31'd0, o_full}, 1);
      tick();
    end
    idle(); tick(); tick(); tick(); tick();

    // MMIO store, MMIO fill and stalled store never enqueue.
    store(32'h4000_0010, 32'hBAD1_0000, 4'hF);
    tick();
    idle(); i_ld_valid = 1; i_ld_addr = 32'h4000_0020; i_ld_data = 32'hBAD2_0000;
    @(negedge i_clk);
    cmp("mmio_store_dropped", {31'd0, o_empty}, 1);
    tick();
    idle(); i_stall = 1; store(32'h100, 32'hBAD3_0000, 4'hF); i_probe_index = 7'h08;
    @(negedge i_clk);
    cmp("mmio_fill_probe", {31'd0, o_probe_hit}, 0);
    tick();
    idle();
    @(negedge i_clk);
    cmp("stall_and_mmio_empty", {31'd0, o_empty}, 1);
    tick();

    // Flush drops the in-flight fill but not the two queued stores.
    amo(32'h200, 32'hB0B0_0000); store(32'h80, 32'hDA7A_000A, 4'hF);
    exp_amo.push_back(mk(7'h00, 1, 32'hB0B0_0000, 0, 4'hF, 4'hF));
    exp_q.push_back(mk(7'h20, 0, 32'hDA7A_000A, 0, 4'hF, 4'hF));
    tick();
    amo(32'h200, 32'hB0B0_0001); store(32'h84, 32'hDA7A_000B, 4'hF);
    i_ld_valid = 1; i_ld_addr = 32'h88; i_ld_data = 32'hDEAD_0001;
    exp_amo.push_back(mk(7'h00, 1, 32'hB0B0_0001, 0, 4'hF, 4'hF));
    exp_q.push_back(mk(7'h21, 0, 32'hDA7A_000B, 0, 4'hF, 4'hF));
    tick();
    idle(); amo(32'h200, 32'hB0B0_0002); i_flush = 1; i_probe_index = 7'h22;
    exp_amo.push_back(mk(7'h00, 1, 32'hB0B0_0002, 0, 4'hF, 4'hF));
    @(negedge i_clk);
    cmp("probe_fill", {31'd0, o_probe_hit}, 1);
    tick();
    idle();
    @(negedge i_clk);
    cmp("probe_fill_flushed", {31'd0, o_probe_hit}, 0);
    tick(); tick(); tick();

    // Reset mid-operation discards two pending stores.
    amo(32'h200, 32'hC0C0_0000); store(32'hC0, 32'hDEAD_00C0, 4'hF);
    exp_amo.push_back(mk(7'h00, 1, 32'hC0C0_0000, 0, 4'hF, 4'hF));
    tick();
    amo(32'h200, 32'hC0C0_0001); store(32'hC4, 32'hDEAD_00C4, 4'hF);
    exp_amo.push_back(mk(7'h00, 1, 32'hC0C0_0001, 0, 4'hF, 4'hF));
    tick();
    idle(); i_rst = 1;
    @(negedge i_clk);
    cmp("midrst_no_write", {31'd0, o_we}, 0);
    tick();
    i_rst = 0;
    @(negedge i_clk);
    cmp("midrst_we", {31'd0, o_we}, 0);
    cmp("midrst_empty", {31'd0, o_empty}, 1);
    tick();

    // Queue works again after reset; store hits the already-valid line.
    store(32'h104, 32'h0BAD_F00D, 4'hF);
    exp_q.push_back(mk(7'h41, 0, 32'h0BAD_F00D, 0, 4'hF, 4'hF));
    tick();
    idle(); tick(); tick();

    cmp("all_writes_seen", exp_q.size() + exp_amo.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_write_queue.md
CACHE_WRITE_QUEUE -- requirements
Module: cache_write_queue

Interface
REQ-001 SHALL have parameters, one per line (name, default, meaning):
- XLEN, 32, data width.
- CacheIndexWidth, 7, set index bits.
- CacheTagWidth, 7, tag bits.
- NumWays, 2, associativity; power of 2, at least 1.
- QueueDepth, 4, pending-write entries; power of 2, at least 2.
- MMIO_ADDR, 32'h4000_0000, base address of the uncached region.

REQ-002 SHALL have ports, one per line (name, direction, width, meaning):
- i_clk in 1: clock.
- i_rst in 1: reset, synchronous, active-high.
- i_stall in 1: pipeline stall.
- i_flush in 1: pipeline flush.
- i_st_addr in XLEN: EX store address.
- i_st_data in XLEN: EX store data.
- i_st_be in XLEN/8: EX store byte enables.
- i_ld_valid in 1: MA load completing.
- i_ld_addr in XLEN: MA load address.
- i_ld_data in XLEN: MA load data.
- i_amo in riscv_pkg::amo_interface_t: AMO write interface.
- i_probe_index in CacheIndexWidth: lookup index to check against pending writes.
- i_rd_tag in NumWays x CacheTagWidth: tags at o_index (same cycle).
- i_rd_valid in NumWays x XLEN/8: valid bits at o_index.
- o_we out 1: cache write enable.
- o_way out $clog2(NumWays) (minimum 1): way selected for the write.
- o_index out CacheIndexWidth: write index, also the tag-read index.
- o_data out XLEN: write data.
- o_tag out CacheTagWidth: write tag.
- o_byte_we out XLEN/8: byte write enables.
- o_valid out XLEN/8: merged valid bits.
- o_full out 1: fewer than 2 free entries; the pipeline stalls on this.
- o_empty out 1: queue empty.
- o_probe_hit out 1: a pending entry matches i_probe_index.

Function
REQ-003 SHALL decode addresses as follows: index = addr[2+:CacheIndexWidth], tag = the next CacheTagWidth bits; the address is MMIO when addr >= MMIO_ADDR.

REQ-004 SHALL enqueue a store entry (byte enables = i_st_be) in the same cycle when |i_st_be, ~i_stall, ~MMIO and ~o_full all hold.

REQ-005 SHALL register a load fill one cycle:
- fill_r <= i_ld_valid & ~MMIO & ~i_stall.
- fill_r is cleared by i_flush.
- The data, index and tag registers are held while i_stall is high.
- fill_r enqueues with byte enables all ones on the following cycle.

REQ-006 SHALL, when fill_r and a store enqueue occur in the same cycle, write both entries in that cycle, with the load fill occupying the older slot.

REQ-007 SHALL give an AMO write (i_amo.write_enable & ~MMIO) the port directly, bypassing the queue, with the queue head held that cycle.
- Byte enables are all ones; o_valid is all ones.

REQ-008 SHALL set o_we when an AMO is active or the queue is non-empty; the head pops in any cycle where o_we is set and no AMO is active.

REQ-009 SHALL set o_index/o_tag/o_data/o_byte_we from the AMO when one is active, else from the head entry.

REQ-010 SHALL select the way as follows:
- Lowest-numbered way with a tag match and any valid bit set.
- Otherwise the lowest-numbered way with valid == 0.
- Otherwise the round-robin victim pointer.
- NumWays==1 forces way 0.

REQ-011 SHALL advance the victim pointer (mod NumWays) only on a write that allocates by pointer.

REQ-012 SHALL merge valid bits:
- Store that hits (REQ-010 match): o_byte_we | i_rd_valid[way].
- Store that allocates: o_byte_we.
- Load or AMO: all ones.

REQ-013 SHALL drive o_probe_hit combinationally when any valid entry, or fill_r, carries index == i_probe_index.

REQ-014 SHALL assert o_full when occupancy >= QueueDepth-1; o_empty when occupancy == 0.

REQ-015 SHALL leave queued entries untouched on i_flush; they are architecturally committed. Only fill_r is dropped.

REQ-016 SHALL handle wrap-around as follows: read and write pointers are $clog2(QueueDepth)+1 bits, and occupancy = wr - rd.

Reset
REQ-017 SHALL, on i_rst, clear the pointers, fill_r and the victim pointer.
- Outputs after reset: o_we=0, o_empty=1, o_full=0, o_probe_hit=0.
- Entry data and fill data registers are not reset.

REQ-018 SHALL, on i_rst asserted mid-operation, discard all pending entries the next cycle, with no write issued in that cycle.

Structure
REQ-019 SHALL define the queue entry struct (index, tag, data, be, is_store) as a typedef in riscv_pkg.

REQ-020 SHALL place the way-select and victim logic in the sub-module cache_way_select.

Verification
REQ-021 Store to 0x0000_0104, be=4'b0011, with an empty cache → next cycle: o_we=1, o_index=0x41, o_way=0, o_valid=4'b0011.

REQ-022 Load fill to 0x0000_0104, followed in the following cycle by a store to the same address with be=4'b1100 → two writes in order: o_valid=4'hF, then 4'hF.

REQ-023 AMO to 0x200 asserted while 2 entries are queued → the AMO writes first; the entries drain on the 2 cycles after.

REQ-024 Stores to 3 distinct tags at index 5, with NumWays=2 → ways 0, 1, 0, and the victim pointer toggles.

REQ-025 Fill QueueDepth-1 entries → o_full=1; a store to 0x4000_0000 (MMIO) is never enqueued.

REQ-026 i_flush with fill_r set and 2 entries queued → the fill is dropped and both entries still write.
